// File: rtl/tessia_pkg.sv
// Shared types and constants for the execute stage: ALU operation codes,
// ARM condition codes and the bit positions of {N,Z,C,V} in the flags word.
package tessia_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU with {N,Z,C,V} flag generation. SUB is A + ~B + 1, so
// C=1 means "no borrow"; C and V are forced to 0 for the logical ops.
module alu_core
    import tessia_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    logic [WIDTH-1:0] b_eff_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic             carry_s;
    logic             ovf_s;

    // Adder path shared by ADD and SUB (SUB inverts B and injects a carry)
    always_comb begin
        b_eff_s = b_i;
        cin_s   = 1'b0;
        if (op_i == ALU_SUB) begin
            b_eff_s = ~b_i;
            cin_s   = 1'b1;
        end else begin
            b_eff_s = b_i;
            cin_s   = 1'b0;
        end
        sum_s = {1'b0, a_i} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    end

    // Result select and carry/overflow per operation
    always_comb begin
        result_o = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        case (op_i)
            ALU_ADD, ALU_SUB: begin
                result_o = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (a_i[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                           (sum_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_ORR: result_o = a_i | b_i;
            default: result_o = {WIDTH{1'b0}};
        endcase
    end

    // Pack the flags word
    always_comb begin
        flags_o         = 4'b0000;
        flags_o[FLAG_N] = result_o[WIDTH-1];
        flags_o[FLAG_Z] = (result_o == {WIDTH{1'b0}});
        flags_o[FLAG_C] = carry_s;
        flags_o[FLAG_V] = ovf_s;
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of a 5-stage ARM-style pipeline: D->E register with flush,
// operand forwarding, ALU, condition evaluation against the architectural
// flags, condition-gated control outputs and the flags register itself.
module execute_stage
    import tessia_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] ExtImmD,
    input  logic [3:0]       WA3D,
    input  logic [1:0]       ALUControlD,
    input  logic             ALUSrcD,
    input  logic [3:0]       CondD,
    input  logic [1:0]       FlagWriteD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             BranchD,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic             FlushE,
    output logic [WIDTH-1:0] ALUResultE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic [3:0]       WA3E,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             MemtoRegE,
    output logic             PCSrcE,
    output logic             BranchTakenE,
    output logic [3:0]       Flags
);

    logic [WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [3:0]       wa3_q, wa3_d, cond_q, cond_d, flags_q, flags_d;
    logic [1:0]       alu_ctrl_q, alu_ctrl_d, flag_write_q, flag_write_d;
    logic             alu_src_q, alu_src_d;
    logic             reg_write_q, reg_write_d, mem_write_q, mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d, pcsrc_q, pcsrc_d;
    logic             branch_q, branch_d;

    logic [WIDTH-1:0] src_a_s, fwd_b_s, src_b_s;
    logic [3:0]       alu_flags_s;
    logic             cond_ex_s;

    // D->E next state: a flush turns the entering instruction into a bubble
    always_comb begin
        rd1_d = RD1D; rd2_d = RD2D; imm_d = ExtImmD; wa3_d = WA3D;
        alu_ctrl_d = ALUControlD; alu_src_d = ALUSrcD; cond_d = CondD;
        flag_write_d = FlagWriteD; reg_write_d = RegWriteD;
        mem_write_d = MemWriteD; mem_to_reg_d = MemtoRegD;
        pcsrc_d = PCSrcD; branch_d = BranchD;
        if (FlushE) begin
            rd1_d = {WIDTH{1'b0}}; rd2_d = {WIDTH{1'b0}}; imm_d = {WIDTH{1'b0}};
            wa3_d = 4'b0000; alu_ctrl_d = 2'b00; alu_src_d = 1'b0;
            cond_d = COND_AL; flag_write_d = 2'b00; reg_write_d = 1'b0;
            mem_write_d = 1'b0; mem_to_reg_d = 1'b0; pcsrc_d = 1'b0;
            branch_d = 1'b0;
        end else begin
            cond_d = CondD;
        end
    end

    // D->E pipeline register; reset takes priority over flush
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd1_q <= {WIDTH{1'b0}}; rd2_q <= {WIDTH{1'b0}}; imm_q <= {WIDTH{1'b0}};
            wa3_q <= 4'b0000; alu_ctrl_q <= 2'b00; alu_src_q <= 1'b0;
            cond_q <= COND_AL; flag_write_q <= 2'b00; reg_write_q <= 1'b0;
            mem_write_q <= 1'b0; mem_to_reg_q <= 1'b0; pcsrc_q <= 1'b0;
            branch_q <= 1'b0;
        end else begin
            rd1_q <= rd1_d; rd2_q <= rd2_d; imm_q <= imm_d;
            wa3_q <= wa3_d; alu_ctrl_q <= alu_ctrl_d; alu_src_q <= alu_src_d;
            cond_q <= cond_d; flag_write_q <= flag_write_d;
            reg_write_q <= reg_write_d; mem_write_q <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d; pcsrc_q <= pcsrc_d;
            branch_q <= branch_d;
        end
    end

    // Forwarding muxes on the registered operands; 11 falls back to the register
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a_s = ResultW;
            2'b10:   src_a_s = ALUResultM;
            default: src_a_s = rd1_q;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b_s = ResultW;
            2'b10:   fwd_b_s = ALUResultM;
            default: fwd_b_s = rd2_q;
        endcase
        if (alu_src_q) begin
            src_b_s = imm_q;
        end else begin
            src_b_s = fwd_b_s;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a_i      (src_a_s),
        .b_i      (src_b_s),
        .op_i     (alu_op_t'(alu_ctrl_q)),
        .result_o (ALUResultE),
        .flags_o  (alu_flags_s)
    );

    // Condition check against the architectural flags register
    always_comb begin
        cond_ex_s = 1'b0;
        case (cond_t'(cond_q))
            COND_EQ: cond_ex_s = flags_q[FLAG_Z];
            COND_NE: cond_ex_s = !flags_q[FLAG_Z];
            COND_CS: cond_ex_s = flags_q[FLAG_C];
            COND_CC: cond_ex_s = !flags_q[FLAG_C];
            COND_MI: cond_ex_s = flags_q[FLAG_N];
            COND_PL: cond_ex_s = !flags_q[FLAG_N];
            COND_VS: cond_ex_s = flags_q[FLAG_V];
            COND_VC: cond_ex_s = !flags_q[FLAG_V];
            COND_HI: cond_ex_s = flags_q[FLAG_C] && !flags_q[FLAG_Z];
            COND_LS: cond_ex_s = !flags_q[FLAG_C] || flags_q[FLAG_Z];
            COND_GE: cond_ex_s = (flags_q[FLAG_N] == flags_q[FLAG_V]);
            COND_LT: cond_ex_s = (flags_q[FLAG_N] != flags_q[FLAG_V]);
            COND_GT: cond_ex_s = !flags_q[FLAG_Z] && (flags_q[FLAG_N] == flags_q[FLAG_V]);
            COND_LE: cond_ex_s = flags_q[FLAG_Z] || (flags_q[FLAG_N] != flags_q[FLAG_V]);
            default: cond_ex_s = 1'b1;
        endcase
    end

    // Flags next state: each field pair updates only when enabled and condition passes
    always_comb begin
        flags_d = flags_q;
        if (cond_ex_s && flag_write_q[1]) begin
            flags_d[FLAG_N] = alu_flags_s[FLAG_N];
            flags_d[FLAG_Z] = alu_flags_s[FLAG_Z];
        end else begin
            flags_d[FLAG_N] = flags_q[FLAG_N];
            flags_d[FLAG_Z] = flags_q[FLAG_Z];
        end
        if (cond_ex_s && flag_write_q[0]) begin
            flags_d[FLAG_C] = alu_flags_s[FLAG_C];
            flags_d[FLAG_V] = alu_flags_s[FLAG_V];
        end else begin
            flags_d[FLAG_C] = flags_q[FLAG_C];
            flags_d[FLAG_V] = flags_q[FLAG_V];
        end
    end

    // Architectural flags register (flush does not cancel the E-stage update)
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign WriteDataE   = fwd_b_s;
    assign WA3E         = wa3_q;
    assign RegWriteE    = reg_write_q & cond_ex_s;
    assign MemWriteE    = mem_write_q & cond_ex_s;
    assign MemtoRegE    = mem_to_reg_q;
    assign PCSrcE       = pcsrc_q & cond_ex_s;
    assign BranchTakenE = branch_q & cond_ex_s;
    assign Flags        = flags_q;

endmodule
